// File: rtl/pw_conv_seq_if.sv
// ---------------------------------------------------------------------------
// pw_conv_seq_if
// Bus bundle for the pointwise convolution sequencer.
//   Input stream : in_valid / in_ready / in_act (IN_CH x DW, channel i at [i*DW +: DW])
//   Output stream: out_valid / out_ready / out_act (OUT_CH x DW, channel o at [o*DW +: DW])
//   Weight write : w_wr_en / w_wr_addr (o*IN_CH+i) / w_wr_data
//   Bias write   : b_wr_en / b_wr_addr (o) / b_wr_data
//   Status       : w_err, one-cycle pulse when a write was dropped while busy
// master = producer/controller side, slave = the convolution block.
// ---------------------------------------------------------------------------
interface pw_conv_seq_if #(
    parameter int IN_CH  = 8,
    parameter int OUT_CH = 16,
    parameter int DW     = 16,
    parameter int WW     = 16,
    parameter int BW     = 32
);
    localparam int WAW = $clog2(OUT_CH * IN_CH);
    localparam int BAW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_CH*DW-1:0]  in_act;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_CH*DW-1:0] out_act;
    logic                 w_wr_en;
    logic [WAW-1:0]       w_wr_addr;
    logic [WW-1:0]        w_wr_data;
    logic                 b_wr_en;
    logic [BAW-1:0]       b_wr_addr;
    logic [BW-1:0]        b_wr_data;
    logic                 w_err;

    modport master (
        output in_valid, in_act, out_ready,
        output w_wr_en, w_wr_addr, w_wr_data,
        output b_wr_en, b_wr_addr, b_wr_data,
        input  in_ready, out_valid, out_act, w_err
    );

    modport slave (
        input  in_valid, in_act, out_ready,
        input  w_wr_en, w_wr_addr, w_wr_data,
        input  b_wr_en, b_wr_addr, b_wr_data,
        output in_ready, out_valid, out_act, w_err
    );
endinterface

// File: rtl/pw_conv_seq.sv
// ---------------------------------------------------------------------------
// pw_conv_seq
// Time-multiplexed pointwise (1x1) convolution layer with ReLU6-style clamp.
// One input channel is consumed per cycle by OUT_CH parallel MAC lanes;
// weights and biases are loaded at runtime through a write port.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - pw_conv_seq_if.slave (input/output streams, weight/bias writes, w_err)
//
// Optional build macro: PW_CONV_ROUND_EN
//   defined   -> round half up before the clamp
//   undefined -> truncating arithmetic right shift
// ---------------------------------------------------------------------------
module pw_conv_seq #(
    parameter int IN_CH     = 8,
    parameter int OUT_CH    = 16,
    parameter int DW        = 16,
    parameter int WW        = 16,
    parameter int BW        = 32,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 15,
    parameter int CLIP_VAL  = 6
) (
    input  logic          clk,
    input  logic          rst,
    pw_conv_seq_if.slave  bus
);
    localparam int CW  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int OW  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int WAW = $clog2(OUT_CH * IN_CH);

    localparam logic [CW-1:0]            LAST_CNT = CW'(IN_CH - 1);
    localparam logic signed [ACC_W-1:0]  CLIP_A   = ACC_W'(CLIP_VAL);
    localparam logic [DW-1:0]            CLIP_O   = DW'(CLIP_VAL);
`ifdef PW_CONV_ROUND_EN
    localparam logic signed [ACC_W-1:0]  RND      = ACC_W'(1) << (FRAC_BITS - 1);
`else
    localparam logic signed [ACC_W-1:0]  RND      = '0;
`endif

    typedef enum logic [1:0] {IDLE, COMPUTE, POST, OUTPUT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            w_err_q;
    logic            load, mac_en, post_en;

    logic signed [DW-1:0]    x_q   [IN_CH];
    logic signed [DW-1:0]    x_cur;
    logic signed [BW-1:0]    b_mem [OUT_CH];

    // Writes only land while idle; the same-cycle vector sees them because
    // the weights are first read one cycle later in COMPUTE.
    logic            wr_ok;
    logic            w_we, b_we;
    logic [OW-1:0]   wr_lane;
    logic [CW-1:0]   wr_idx;

    assign wr_ok   = (state_q == IDLE);
    assign w_we    = bus.w_wr_en & wr_ok;
    assign b_we    = bus.b_wr_en & wr_ok;
    assign wr_lane = OW'(bus.w_wr_addr / WAW'(IN_CH));
    assign wr_idx  = CW'(bus.w_wr_addr % WAW'(IN_CH));
    assign x_cur   = x_q[cnt_q];

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        mac_en      = 1'b0;
        post_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                mac_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = POST;
                end
            end
            POST: begin
                post_en     = 1'b1;
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            w_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            w_err_q     <= (bus.w_wr_en | bus.b_wr_en) & ~wr_ok;
        end
    end

    // Bias store (not reset; undefined until written).
    always_ff @(posedge clk) begin
        if (b_we) begin
            b_mem[bus.b_wr_addr] <= bus.b_wr_data;
        end
    end

    // Activation capture.
    genvar gi;
    generate
        for (gi = 0; gi < IN_CH; gi++) begin : g_xcap
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_q[gi] <= '0;
                end else if (load) begin
                    x_q[gi] <= bus.in_act[gi*DW +: DW];
                end
            end
        end

        // One MAC lane per output channel, each with its own weight column
        // so all lanes can read weight [o][cnt] in the same cycle.
        for (gi = 0; gi < OUT_CH; gi++) begin : g_lane
            logic signed [WW-1:0]    w_mem [IN_CH];
            logic signed [DW+WW-1:0] prod;
            logic signed [ACC_W-1:0] acc_q;
            logic signed [ACC_W-1:0] s;
            logic signed [ACC_W-1:0] q;
            logic [DW-1:0]           res;
            logic [DW-1:0]           out_q;

            always_ff @(posedge clk) begin
                if (w_we && (wr_lane == OW'(gi))) begin
                    w_mem[wr_idx] <= bus.w_wr_data;
                end
            end

            assign prod = w_mem[cnt_q] * x_cur;
            assign s    = acc_q + ACC_W'(b_mem[gi]);
            assign q    = (s + RND) >>> FRAC_BITS;

            // Negative sums clamp to zero before any rounding decision.
            always_comb begin
                res = q[DW-1:0];
                if (s[ACC_W-1]) begin
                    res = '0;
                end else if (q > CLIP_A) begin
                    res = CLIP_O;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q <= '0;
                    out_q <= '0;
                end else begin
                    if (load) begin
                        acc_q <= '0;
                    end else if (mac_en) begin
                        acc_q <= acc_q + ACC_W'(prod);
                    end
                    if (post_en) begin
                        out_q <= res;
                    end
                end
            end

            assign bus.out_act[gi*DW +: DW] = out_q;
        end
    endgenerate

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.w_err     = w_err_q;

endmodule
